data_mem_bus: RTL
=================

Name: data_mem_bus

Overview:
- Parametrised byte-addressed data memory for the core's load/store path, behind a req/gnt/rvalid handshake.
- Adds the following:
  - byte-enable writes
  - configurable depth and access latency
  - single-outstanding-transaction FSM
  - out-of-range error response
- Sits between the LSU and the testbench memory map; for simulation and FPGA-style inference.

Parameters:
- ADDR_WIDTH, 32, width of addr_i (byte address).
- DATA_WIDTH, 32, word width; must be 32 or 64 (multiple of 8).
- DEPTH_BYTES, 4096, memory size in bytes; power of two, multiple of DATA_WIDTH/8.
- LATENCY, 1, cycles from grant edge to rvalid_o; legal range 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset.
- req_i  in  1  transaction request.
- gnt_o  out  1  request accepted this cycle.
- addr_i  in  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored (word-aligned).
- we_i  in  1  1 = write, 0 = read.
- be_i  in  DATA_WIDTH/8  byte enables for writes; ignored on reads.
- wdata_i  in  DATA_WIDTH  write data, byte lane k = wdata_i[8k+7:8k].
- rvalid_o  out  1  response valid, one-cycle pulse per transaction.
- rdata_o  out  DATA_WIDTH  read data; valid with rvalid_o.
- err_o  out  1  out-of-range flag; valid with rvalid_o.

Interface: one clock; reset is asynchronous and active-high (clk_i, rst_i).

Behaviour:
- Storage: DEPTH_BYTES x 8-bit array; not cleared by reset; zero-initialised at time 0 in simulation.
- FSM states: IDLE, WAIT, RESP. Reset state IDLE.
- Reset values: rvalid_o=0, rdata_o=0, err_o=0. gnt_o=0 while rst_i is high.
- gnt_o = req_i && state==IDLE (combinational). Accept = req_i && gnt_o at a rising edge.
- On accept, latch aligned address, we_i, be_i and wdata_i. Load wait counter cnt with LATENCY-1.
  - If LATENCY==1, go directly to RESP.
  - Otherwise go to WAIT.
- WAIT: cnt decrements each cycle; when cnt==0 at an edge, go to RESP.
- Commit: the array access happens on the edge entering RESP.
  - Write: byte k is written iff be_i[k]=1.
  - Read: the word is registered into rdata_o.
- Address-to-response latency is exactly LATENCY cycles: a request granted in cycle N gives rvalid_o=1 in cycle N+LATENCY.
- RESP: lasts one cycle, during which rvalid_o=1, then returns to IDLE.
  - gnt_o is 0 in RESP, so the next accept is at the earliest in cycle N+LATENCY+1.
- rdata_o is 0 whenever rvalid_o=0, and 0 for write responses.
- Out-of-range: aligned address >= DEPTH_BYTES.
  - No array write occurs.
  - Response has rdata_o=0 and err_o=1.
  - Latency is unchanged.
- err_o is 0 whenever rvalid_o=0.
- be_i all-zero write: valid transaction, no bytes modified, normal response.
- Read-after-write to the same word: the read returns the committed write data (no bypass needed; the write commits first).
- Reset mid-transaction (WAIT or RESP):
  - Return to IDLE; outputs go to their reset values immediately.
  - A write not yet committed is dropped.
  - A write already committed stays in memory.
- req_i may drop while not granted; there is no requirement to hold it.

Optional Feature:
- Macro: DMEM_RAND_STALL_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded to 8'hA5 on reset, advances on every accept.
  - Its two LSBs, sampled at accept, add 0..3 extra WAIT cycles, so latency = LATENCY + lfsr[1:0].
  - Ordering, data and error semantics are unchanged.
- Not defined: latency is exactly LATENCY; no LFSR logic is present.

Test Plan:
- Write addr 0x10, be 4'b1111, wdata 0xDEADBEEF, then read 0x10 -> rdata_o=0xDEADBEEF, err_o=0; with LATENCY=1, rvalid_o exactly one cycle after the grant.
- Write 0x20 with 0x11223344 (be 1111), then 0xAABBCCDD with be 4'b0101, then read 0x22 -> rdata_o=0x11BB33DD (addr LSBs ignored).
- LATENCY=4: read granted at cycle 10 -> rvalid_o high only in cycle 14; gnt_o=0 in cycles 11-14 even with req_i held high.
- Read/write at addr 0x1000 (DEPTH_BYTES=4096) -> err_o=1, rdata_o=0; a subsequent read of 0x0 returns unmodified data.
- LATENCY=3: write 0x55 to 0x40, assert rst_i one cycle after the grant -> no rvalid_o; a later read of 0x40 returns the prior value 0x00000000.
- DMEM_RAND_STALL_EN defined: 16 back-to-back reads -> each latency in [LATENCY, LATENCY+3], the sequence matches the LFSR model from seed 0xA5, and the data is correct.

Source files
------------

// File: rtl/data_mem_bus_if.sv
// Request/response bus between the LSU and the data memory.
// Macro: none.
// Signals: req_i/addr_i/we_i/be_i/wdata_i from master to slave;
//          gnt_o/rvalid_o/rdata_o/err_o from slave to master.
// Modports: master (LSU side), slave (memory side).
interface data_mem_bus_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  req_i;
    logic                  gnt_o;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic                  we_i;
    logic [BE_WIDTH-1:0]   be_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  rvalid_o;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  err_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/data_mem_bus.sv
// Byte-addressed data memory behind a req/gnt/rvalid handshake, one
// transaction outstanding at a time, fixed access latency and an error
// response for addresses beyond the array.
// Optional macro DMEM_RAND_STALL_EN: adds 0..3 pseudo-random wait cycles
// per transaction, drawn from an 8-bit LFSR.
// Ports: clk_i     rising-edge clock
//        rst_i     asynchronous active-high reset
//        bus       data_mem_bus_if.slave (req/gnt, addr, we, be, wdata,
//                  rvalid, rdata, err)
module data_mem_bus #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_BYTES = 4096,
    parameter int unsigned LATENCY     = 1
) (
    input logic           clk_i,
    input logic           rst_i,
    data_mem_bus_if.slave bus
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, load_cnt;
    logic [ADDR_WIDTH-1:0] addr_q, cur_addr;
    logic                  we_q, cur_we;
    logic [BYTES-1:0]      be_q, cur_be;
    logic [DATA_WIDTH-1:0] wdata_q, cur_wdata, rd_word;
    logic                  rvalid_q, err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  accept, commit, oor;
    logic [IDX_W-1:0]      idx;
    logic [7:0]            mem [DEPTH_BYTES];
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^bus.addr_i[OFF_W-1:0];

    assign bus.gnt_o    = bus.req_i && (state_q == IDLE) && !rst_i;
    assign accept       = bus.req_i && bus.gnt_o;
    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;
    assign bus.err_o    = err_q;

`ifdef DMEM_RAND_STALL_EN
    logic [7:0] lfsr_q;

    // Fibonacci LFSR, taps 8,6,5,4; steps once per accepted request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       lfsr_q <= 8'hA5;
        else if (accept) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    assign load_cnt = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[1:0]);
`else
    assign load_cnt = CNT_W'(LATENCY - 1);
`endif

    // cnt holds the number of WAIT cycles still to spend before RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = load_cnt;
                    state_d = (load_cnt == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Transaction capture at accept
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= {bus.addr_i[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
            we_q    <= bus.we_i;
            be_q    <= bus.be_i;
            wdata_q <= bus.wdata_i;
        end
    end

    // With no WAIT phase the commit edge is the accept edge, so use the live bus
    always_comb begin
        if (state_q == IDLE) begin
            cur_addr  = {bus.addr_i[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
            cur_we    = bus.we_i;
            cur_be    = bus.be_i;
            cur_wdata = bus.wdata_i;
        end else begin
            cur_addr  = addr_q;
            cur_we    = we_q;
            cur_be    = be_q;
            cur_wdata = wdata_q;
        end
    end

    assign commit = (state_d == RESP) && !rst_i;
    assign oor    = (cur_addr >> IDX_W) != '0;
    assign idx    = cur_addr[IDX_W-1:0];

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < int'(BYTES); k++) rd_word[8*k +: 8] = mem[idx + IDX_W'(k)];
    end

    // Storage keeps its contents across reset
    always_ff @(posedge clk_i) begin
        if (commit && cur_we && !oor) begin
            for (int k = 0; k < int'(BYTES); k++) begin
                if (cur_be[k]) mem[idx + IDX_W'(k)] <= cur_wdata[8*k +: 8];
            end
        end
    end

    // Response registers; non-zero only during the single RESP cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= commit;
            rdata_q  <= (commit && !cur_we && !oor) ? rd_word : '0;
            err_q    <= commit && oor;
        end
    end
endmodule
